// File: rtl/kbd_pkg.sv
// Shared constants, FSM state type and byte classification for the PS/2-to-XT scancode front end.
package kbd_pkg;

  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_EXT0     = 8'hE0;
  localparam logic [7:0] PS2_EXT1     = 8'hE1;
  localparam logic [7:0] PS2_BAT      = 8'hAA;
  localparam int         XT_BREAK_BIT = 7;

  typedef enum logic {
    S_MAKE  = 1'b0,
    S_BREAK = 1'b1
  } kbd_state_e;

  // Bytes that go through the set-2 to set-1 table; 00 is a protocol byte, not a key.
  function automatic logic is_ps2_code(input logic [7:0] b);
    return (b != 8'h00) && (b <= 8'h83);
  endfunction

endpackage

// File: rtl/ps2_set1_rom.sv
// Combinational set-2 to XT set-1 make-code table for set-2 codes 00-7F; 00 means untranslatable.
module ps2_set1_rom (
  input  logic [6:0] i_code,
  output logic [7:0] o_xt
);

  always_comb begin
    o_xt = 8'h00;
    case (i_code)
      7'h01: o_xt = 8'h43;  7'h03: o_xt = 8'h3F;  7'h04: o_xt = 8'h3D;  7'h05: o_xt = 8'h3B;
      7'h06: o_xt = 8'h3C;  7'h07: o_xt = 8'h58;  7'h09: o_xt = 8'h44;  7'h0A: o_xt = 8'h42;
      7'h0B: o_xt = 8'h40;  7'h0C: o_xt = 8'h3E;  7'h0D: o_xt = 8'h0F;  7'h0E: o_xt = 8'h29;
      7'h11: o_xt = 8'h38;  7'h12: o_xt = 8'h2A;  7'h14: o_xt = 8'h1D;  7'h15: o_xt = 8'h10;
      7'h16: o_xt = 8'h02;  7'h1A: o_xt = 8'h2C;  7'h1B: o_xt = 8'h1F;  7'h1C: o_xt = 8'h1E;
      7'h1D: o_xt = 8'h11;  7'h1E: o_xt = 8'h03;  7'h21: o_xt = 8'h2E;  7'h22: o_xt = 8'h2D;
      7'h23: o_xt = 8'h20;  7'h24: o_xt = 8'h12;  7'h25: o_xt = 8'h05;  7'h26: o_xt = 8'h04;
      7'h29: o_xt = 8'h39;  7'h2A: o_xt = 8'h2F;  7'h2B: o_xt = 8'h21;  7'h2C: o_xt = 8'h14;
      7'h2D: o_xt = 8'h13;  7'h2E: o_xt = 8'h06;  7'h31: o_xt = 8'h31;  7'h32: o_xt = 8'h30;
      7'h33: o_xt = 8'h23;  7'h34: o_xt = 8'h22;  7'h35: o_xt = 8'h15;  7'h36: o_xt = 8'h07;
      7'h3A: o_xt = 8'h32;  7'h3B: o_xt = 8'h24;  7'h3C: o_xt = 8'h16;  7'h3D: o_xt = 8'h08;
      7'h3E: o_xt = 8'h09;  7'h41: o_xt = 8'h33;  7'h42: o_xt = 8'h25;  7'h43: o_xt = 8'h17;
      7'h44: o_xt = 8'h18;  7'h45: o_xt = 8'h0B;  7'h46: o_xt = 8'h0A;  7'h49: o_xt = 8'h34;
      7'h4A: o_xt = 8'h35;  7'h4B: o_xt = 8'h26;  7'h4C: o_xt = 8'h27;  7'h4D: o_xt = 8'h19;
      7'h4E: o_xt = 8'h0C;  7'h52: o_xt = 8'h28;  7'h54: o_xt = 8'h1A;  7'h55: o_xt = 8'h0D;
      7'h58: o_xt = 8'h3A;  7'h59: o_xt = 8'h36;  7'h5A: o_xt = 8'h1C;  7'h5B: o_xt = 8'h1B;
      7'h5D: o_xt = 8'h2B;  7'h61: o_xt = 8'h56;  7'h66: o_xt = 8'h0E;  7'h69: o_xt = 8'h4F;
      7'h6B: o_xt = 8'h4B;  7'h6C: o_xt = 8'h47;  7'h70: o_xt = 8'h52;  7'h71: o_xt = 8'h53;
      7'h72: o_xt = 8'h50;  7'h73: o_xt = 8'h4C;  7'h74: o_xt = 8'h4D;  7'h75: o_xt = 8'h48;
      7'h76: o_xt = 8'h01;  7'h77: o_xt = 8'h45;  7'h78: o_xt = 8'h57;  7'h79: o_xt = 8'h4E;
      7'h7A: o_xt = 8'h51;  7'h7B: o_xt = 8'h4A;  7'h7C: o_xt = 8'h37;  7'h7D: o_xt = 8'h49;
      7'h7E: o_xt = 8'h46;
      default: o_xt = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_xt_fifo.sv
// Set-2 to XT translator with break-prefix merge, queued in a register FIFO drained via port 60h.
// Handshake: ps2_hit and kbd_pop are one-cycle strobes taken on the edge that samples them; kbd_ready flags a valid head in kbd_data.
module ps2_xt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_hit,
  input  logic       kbd_pop,
  input  logic       kbd_flush,
  output logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       kbd_irq,
  output logic       kbd_overflow,
  output kbd_state_e dbg_state
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  kbd_state_e    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_mem [DEPTH];
  logic          r_irq;
  logic          r_overflow;

  logic [7:0]    w_rom;
  logic [7:0]    w_xt;
  logic          w_push;
  logic [7:0]    w_push_data;
  kbd_state_e    w_next_state;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic [AW:0]   w_count_next;

  ps2_set1_rom u_rom (
    .i_code (ps2_data[6:0]),
    .o_xt   (w_rom)
  );

  // 83 (F7) is the only translatable code with bit 7 set.
  assign w_xt = (ps2_data == 8'h83) ? 8'h41 : (ps2_data[7] ? 8'h00 : w_rom);

  always_comb begin
    w_push       = 1'b0;
    w_push_data  = ps2_data;
    w_next_state = r_state;
    if (ps2_hit) begin
      if (ps2_data == PS2_BREAK) begin
        w_next_state = S_BREAK;
      end else if ((ps2_data == PS2_EXT0) || (ps2_data == PS2_EXT1)) begin
        w_push = 1'b1;
      end else if (ps2_data == PS2_BAT) begin
        w_push       = 1'b1;
        w_next_state = S_MAKE;
      end else if (is_ps2_code(ps2_data)) begin
        w_next_state = S_MAKE;
        w_push       = (w_xt != 8'h00);
        w_push_data  = w_xt;
        w_push_data[XT_BREAK_BIT] = w_xt[XT_BREAK_BIT] | (r_state == S_BREAK);
      end
    end
  end

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == FULL_CNT);
  assign w_pop        = kbd_pop && !w_empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
  assign w_wr         = w_push && (!w_full || w_pop);
  assign w_count_next = r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_MAKE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_irq      <= 1'b0;
      r_overflow <= 1'b0;
    end else if (kbd_flush) begin
      r_state    <= S_MAKE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_irq      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_irq   <= (w_count_next != '0) && (w_empty || w_pop);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr && !kbd_flush) r_mem[r_wr_ptr] <= w_push_data;
  end

  assign kbd_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign kbd_ready    = !w_empty;
  assign kbd_irq      = r_irq;
  assign kbd_overflow = r_overflow;
  assign dbg_state    = r_state;

endmodule
